// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter.
// Master 0 is the instruction fetch unit and master 1 is the load/store unit.
// One read transaction (AR plus every R beat) owns the slave port at a time.
// It also flags bursts whose rlast does not land on the beat announced by arlen.
module axi_rd_arbiter #(
    parameter int RR = 1,   // 1: round-robin, 0: fixed priority with master 1 winning
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,        // asynchronous, active-low

    // master 0 (IFU)
    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [AW-1:0] m0_araddr,
    input  logic [7:0]    m0_arlen,
    input  logic [2:0]    m0_arsize,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    output logic          m0_rlast,

    // master 1 (LSU)
    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [AW-1:0] m1_araddr,
    input  logic [7:0]    m1_arlen,
    input  logic [2:0]    m1_arsize,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          m1_rlast,

    // slave read port
    output logic          s_arvalid,
    input  logic          s_arready,
    output logic [AW-1:0] s_araddr,
    output logic [7:0]    s_arlen,
    output logic [2:0]    s_arsize,
    input  logic          s_rvalid,
    output logic          s_rready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    input  logic          s_rlast,

    // status
    output logic          busy,
    output logic          owner,
    output logic          err_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] beat_lim_q, beat_lim_d;
    logic       err_last_q, err_last_d;

    logic       own_arvalid;
    logic       own_rready;
    logic       grant;

    // Route the current owner's handshake inputs onto common nets.
    always_comb begin
        own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
        own_rready  = owner_q ? m1_rready  : m0_rready;
    end

    // Pick the next owner: a lone requester always wins; contention goes to
    // the round-robin pointer, or to master 1 in fixed-priority mode.
    always_comb begin
        grant = m1_arvalid;
        if ((RR != 0) && m0_arvalid && m1_arvalid) begin
            grant = rr_ptr_q;
        end
    end

    // Next-state logic: grant, address handshake, beat counting and the
    // burst-length check. The burst ends only on s_rlast.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat_lim_d = beat_lim_q;
        err_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    owner_d = grant;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (own_arvalid && s_arready) begin
                    beat_lim_d = owner_q ? m1_arlen : m0_arlen;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (s_rvalid && own_rready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Mismatch when rlast arrives early/late relative to arlen.
                    err_last_d = s_rlast ^ (beat_cnt_q == beat_lim_q);
                    if (s_rlast) begin
                        state_d = IDLE;
                        if (RR != 0) begin
                            rr_ptr_d = ~owner_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers; reset discards any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= 8'd0;
            beat_lim_q <= 8'd0;
            err_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            beat_lim_q <= beat_lim_d;
            err_last_q <= err_last_d;
        end
    end

    // Channel muxing: AR path open only in ADDR, R path only in DATA; all
    // other outputs are held at zero.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rlast   = 1'b0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        s_rready   = 1'b0;
        case (state_q)
            ADDR: begin
                s_arvalid = own_arvalid;
                s_araddr  = owner_q ? m1_araddr : m0_araddr;
                s_arlen   = owner_q ? m1_arlen  : m0_arlen;
                s_arsize  = owner_q ? m1_arsize : m0_arsize;
                if (owner_q) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
            end
            DATA: begin
                s_rready = own_rready;
                if (owner_q) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;
    assign err_last = err_last_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axi_rd_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main DUT (round-robin) stimulus and observation
    logic        arvalid [2];
    logic [31:0] araddr  [2];
    logic [7:0]  arlen   [2];
    logic [2:0]  arsize  [2];
    logic        rready  [2];
    logic        arready [2];
    logic        rvalid  [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rlast   [2];
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_rresp;
    logic        busy, owner, err_last;

    // fixed-priority DUT signals
    logic        f_m0_arvalid, f_m1_arvalid, f_m0_arready, f_m1_arready;
    logic [31:0] f_m0_araddr, f_m1_araddr, f_m0_rdata, f_m1_rdata, f_s_araddr, f_s_rdata;
    logic [7:0]  f_m0_arlen, f_m1_arlen, f_s_arlen;
    logic [2:0]  f_m0_arsize, f_m1_arsize, f_s_arsize;
    logic        f_m0_rvalid, f_m1_rvalid, f_m0_rready, f_m1_rready, f_m0_rlast, f_m1_rlast;
    logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_rresp;
    logic        f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rready, f_s_rlast;
    logic        f_busy, f_owner, f_err_last;

    int n_chk = 0;
    int n_err = 0;
    int busy_cyc = 0;
    int err_cyc = 0;

    axi_rd_arbiter #(.RR(1), .AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(arvalid[0]), .m0_arready(arready[0]), .m0_araddr(araddr[0]),
        .m0_arlen(arlen[0]), .m0_arsize(arsize[0]), .m0_rvalid(rvalid[0]),
        .m0_rready(rready[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]),
        .m1_arvalid(arvalid[1]), .m1_arready(arready[1]), .m1_araddr(araddr[1]),
        .m1_arlen(arlen[1]), .m1_arsize(arsize[1]), .m1_rvalid(rvalid[1]),
        .m1_rready(rready[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .busy(busy), .owner(owner), .err_last(err_last)
    );

    axi_rd_arbiter #(.RR(0), .AW(32), .DW(32)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_arvalid(f_m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(f_m0_araddr),
        .m0_arlen(f_m0_arlen), .m0_arsize(f_m0_arsize), .m0_rvalid(f_m0_rvalid),
        .m0_rready(f_m0_rready), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
        .m1_arvalid(f_m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(f_m1_araddr),
        .m1_arlen(f_m1_arlen), .m1_arsize(f_m1_arsize), .m1_rvalid(f_m1_rvalid),
        .m1_rready(f_m1_rready), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
        .s_arvalid(f_s_arvalid), .s_arready(f_s_arready), .s_araddr(f_s_araddr),
        .s_arlen(f_s_arlen), .s_arsize(f_s_arsize), .s_rvalid(f_s_rvalid), .s_rready(f_s_rready),
        .s_rdata(f_s_rdata), .s_rresp(f_s_rresp), .s_rlast(f_s_rlast),
        .busy(f_busy), .owner(f_owner), .err_last(f_err_last)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    // A transaction is "open" from grant until the beat carrying rlast; its
    // address phase is "done" once the slave accepted the AR.
    bit          mb_busy, mb_ar_done, mb_owner, mb_pref, mb_err;
    int          mb_seen, mb_expect;
    int          o;
    logic [1:0]  e_ardy, e_rv, e_rl;
    logic [1:0][31:0] e_rd;
    logic [1:0][1:0]  e_rr;
    logic        e_sarv, e_srr;
    logic [31:0] e_sadr;
    logic [7:0]  e_slen;
    logic [2:0]  e_ssz;
    bit          on_time;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                mb_busy = 0; mb_ar_done = 0; mb_owner = 0; mb_pref = 0;
                mb_err = 0; mb_seen = 0; mb_expect = 0;
            end
            o = int'(mb_owner);
            e_ardy = '0; e_rv = '0; e_rl = '0; e_rd = '0; e_rr = '0;
            e_sarv = 0; e_srr = 0; e_sadr = '0; e_slen = '0; e_ssz = '0;
            if (mb_busy && !mb_ar_done) begin
                e_sarv    = arvalid[o];
                e_sadr    = araddr[o];
                e_slen    = arlen[o];
                e_ssz     = arsize[o];
                e_ardy[o] = s_arready;
            end
            if (mb_busy && mb_ar_done) begin
                e_rv[o] = s_rvalid;
                e_rd[o] = s_rdata;
                e_rr[o] = s_rresp;
                e_rl[o] = s_rlast;
                e_srr   = rready[o];
            end
            chk("status", 128'({busy, owner, err_last}), 128'({mb_busy, mb_owner, mb_err}));
            chk("ar_chan", 128'({arready[1], arready[0], s_arvalid, s_araddr, s_arlen, s_arsize}),
                128'({e_ardy, e_sarv, e_sadr, e_slen, e_ssz}));
            chk("r_chan", 128'({rvalid[1], rdata[1], rresp[1], rlast[1],
                                rvalid[0], rdata[0], rresp[0], rlast[0], s_rready}),
                128'({e_rv[1], e_rd[1], e_rr[1], e_rl[1], e_rv[0], e_rd[0], e_rr[0], e_rl[0], e_srr}));
            if (busy) busy_cyc++;
            if (err_last) err_cyc++;
            if (reset) begin
                mb_err = 0;
                if (!mb_busy) begin
                    if (arvalid[0] || arvalid[1]) begin
                        mb_busy    = 1;
                        mb_ar_done = 0;
                        mb_owner   = (arvalid[0] && arvalid[1]) ? mb_pref : arvalid[1];
                    end
                end else if (!mb_ar_done) begin
                    if (arvalid[o] && s_arready) begin
                        mb_ar_done = 1;
                        mb_seen    = 0;
                        mb_expect  = int'(arlen[o]) + 1;
                    end
                end else if (s_rvalid && rready[o]) begin
                    mb_seen++;
                    on_time = (mb_seen == mb_expect);
                    mb_err  = (s_rlast != on_time);
                    if (s_rlast) begin
                        mb_busy    = 0;
                        mb_ar_done = 0;
                        mb_pref    = !mb_owner;
                    end
                end
            end
        end
    end

    // Slave responder for one transaction of master `who`: accepts the AR,
    // waits one cycle, then returns nbeats beats (rlast on the final one).
    // abort_after >= 0 stops after that many beats, leaving the burst open.
    task automatic serve(input int who, input int nbeats, input int abort_after,
                         input logic [31:0] base, input bit tog, input bit other_req,
                         output int got);
        int guard;
        int ar_seen;
        int cyc;
        bit hs;
        got = 0; ar_seen = 0; cyc = 0; guard = 0;
        #1;
        while (!s_arvalid && guard < 20) begin
            tick(); #1; guard++;
        end
        chk("grant_wait", 128'(guard < 20), 128'(1));
        chk("grant_owner", 128'(owner), 128'(who));
        tick();
        arvalid[who] = 1'b0;
        if (other_req) arvalid[1-who] = 1'b1;
        #1;
        if (arready[0] || arready[1]) ar_seen++;
        tick();
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_after) break;
            s_rvalid = 1'b1;
            s_rdata  = base + 32'(b);
            s_rresp  = 2'(b);
            s_rlast  = (b == nbeats - 1);
            hs = 0; guard = 0;
            while (!hs && guard < 10) begin
                rready[who] = tog ? (cyc % 2 == 0) : 1'b1;
                cyc++;
                #1;
                if (arready[0] || arready[1]) ar_seen++;
                if (rready[who] && rvalid[who]) begin
                    hs = 1;
                    got++;
                    chk("beat_data", 128'(rdata[who]), 128'(base + 32'(b)));
                end
                tick();
                guard++;
            end
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        rready[who] = 1'b1;
        chk("no_ar_in_data", 128'(ar_seen), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int guard;
        reset = 1'b0;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arvalid[i] = 1'b0; araddr[i] = '0; arlen[i] = '0; arsize[i] = 3'd2; rready[i] = 1'b1;
        end
        f_m0_arvalid = 0; f_m1_arvalid = 0;
        f_m0_araddr = 32'h0000_0100; f_m1_araddr = 32'h0000_0200;
        f_m0_arlen = 0; f_m1_arlen = 0; f_m0_arsize = 3'd2; f_m1_arsize = 3'd2;
        f_m0_rready = 1; f_m1_rready = 1;
        f_s_arready = 1; f_s_rvalid = 1; f_s_rlast = 1; f_s_rdata = 32'h0; f_s_rresp = 2'b00;

        // reset holds everything idle even with both masters requesting
        araddr[0] = 32'h0000_1000; araddr[1] = 32'h0000_2000;
        arvalid[0] = 1'b1; arvalid[1] = 1'b1;
        repeat (2) tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_owner", 128'(owner), 128'(0));
        chk("rst_ready", 128'({arready[1], arready[0], s_arvalid, s_rready}), 128'(0));
        reset = 1'b1;

        // round-robin alternation: 0, 1, 0, 1
        serve(0, 1, -1, 32'hA000_0000, 0, 0, got);
        arvalid[0] = 1'b1;
        serve(1, 1, -1, 32'hB000_0000, 0, 0, got);
        arvalid[1] = 1'b1;
        serve(0, 1, -1, 32'hA000_0001, 0, 0, got);
        arvalid[0] = 1'b1;
        serve(1, 1, -1, 32'hB000_0001, 0, 0, got);
        arvalid[0] = 1'b0;

        // single IFU read
        tick();
        busy_cyc = 0;
        araddr[0] = 32'h3000_0000; arlen[0] = 8'd0; arvalid[0] = 1'b1;
        serve(0, 1, -1, 32'hDEAD_BEEF, 0, 0, got);
        chk("ifu_beats", 128'(got), 128'(1));
        chk("ifu_busy_cycles", 128'(busy_cyc), 128'(3));

        // LSU burst of 4 with rready toggling, m0 requesting during DATA
        araddr[1] = 32'h4000_0040; arlen[1] = 8'd3; arsize[1] = 3'd3; arvalid[1] = 1'b1;
        araddr[0] = 32'h3000_0010; arlen[0] = 8'd0;
        serve(1, 4, -1, 32'h1111_0000, 1, 1, got);
        chk("burst_beats", 128'(got), 128'(4));
        serve(0, 1, -1, 32'h2222_0000, 0, 0, got);

        // early rlast: arlen=3, rlast on the second beat
        err_cyc = 0;
        arlen[0] = 8'd3; arvalid[0] = 1'b1;
        serve(0, 2, -1, 32'h3333_0000, 0, 0, got);
        tick();
        chk("early_rlast_err", 128'(err_cyc), 128'(1));
        chk("early_rlast_idle", 128'(busy), 128'(0));

        // late rlast: arlen=1, rlast only on the third beat
        err_cyc = 0;
        arlen[1] = 8'd1; arvalid[1] = 1'b1;
        serve(1, 3, -1, 32'h4444_0000, 0, 0, got);
        tick();
        chk("late_rlast_beats", 128'(got), 128'(3));
        chk("late_rlast_err", 128'(err_cyc), 128'(2));

        // reset in the middle of a 4-beat burst after one beat
        arlen[0] = 8'd3; arvalid[0] = 1'b1;
        serve(0, 4, 1, 32'h5555_0000, 0, 0, got);
        chk("abort_beats", 128'(got), 128'(1));
        chk("abort_busy_before", 128'(busy), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_outs", 128'({busy, owner, s_rready, rvalid[0], rvalid[1], s_arvalid}), 128'(0));
        tick();
        tick();
        reset = 1'b1;
        arlen[0] = 8'd0; araddr[0] = 32'h3000_0020; arvalid[0] = 1'b1;
        serve(0, 1, -1, 32'h5555_AAAA, 0, 0, got);
        chk("post_rst_beats", 128'(got), 128'(1));

        // fixed priority: master 1 wins every contended grant, m0 only alone
        f_m0_arvalid = 1'b1; f_m1_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            guard = 0;
            #1;
            while (!f_s_arvalid && guard < 20) begin
                tick(); #1; guard++;
            end
            chk("fp_wait", 128'(guard < 20), 128'(1));
            chk("fp_owner", 128'(f_owner), 128'((k < 3) ? 1 : 0));
            chk("fp_arready", 128'({f_m1_arready, f_m0_arready}), 128'((k < 3) ? 2'b10 : 2'b01));
            tick();
            if (k == 2) f_m1_arvalid = 1'b0;
        end
        f_m0_arvalid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
